coin_score_tracker: RTL and testbench

// - Game-side producer of the HUD numbers: accumulates coin pickups and point awards into BCD registers.
// - Supplies per-digit values for the font-ROM text renderers (coin digits, 6-digit score, lives).
// - Sits between collision/game logic and the HUD pixel path.
// - Processes events serially through a small FSM and award FIFO, so that same-frame events are never dropped.

---
 rtl/coin_score_pkg.sv | 49 ++++
 rtl/coin_score_tracker_fifo.sv | 55 +++++
 rtl/coin_score_tracker.sv | 186 ++++++++++++++++++
 tb/tb_coin_score_tracker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_score_pkg.sv
// Shared types and BCD helpers for the HUD coin/score tracker.
package coin_score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COIN_INC  = 2'd1,
    ST_SCORE_ADD = 2'd2,
    ST_COMMIT    = 2'd3
  } fsm_state_t;

  typedef enum logic [1:0] {
    GS_TITLE   = 2'b00,
    GS_PLAYING = 2'b01,
    GS_DYING   = 2'b10,
    GS_OVER    = 2'b11
  } game_state_t;

  typedef logic [2:0] award_code_t;

  localparam logic [23:0] SCORE_MAX = 24'h999999;

  // Points awarded per code, already in 6-digit BCD.
  function automatic logic [23:0] award_addend(input award_code_t code);
    logic [23:0] v;
    case (code)
      3'd0:    v = 24'h000100;
      3'd1:    v = 24'h000200;
      3'd2:    v = 24'h000400;
      3'd3:    v = 24'h000500;
      3'd4:    v = 24'h000800;
      3'd5:    v = 24'h001000;
      3'd6:    v = 24'h002000;
      default: v = 24'h005000;
    endcase
    return v;
  endfunction

  // One BCD digit add; returns {carry_out, sum_digit}.
  function automatic logic [4:0] bcd_add_digit(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] raw;
    logic [4:0] adj;
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj = raw - 5'd10;
    if (raw > 5'd9) return {1'b1, adj[3:0]};
    return {1'b0, raw[3:0]};
  endfunction

endpackage

// File: rtl/coin_score_tracker_fifo.sv
// Small award-code FIFO; ready is the registered "not full" view.
module award_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       push_valid_i,
  output logic       push_ready_o,
  input  logic [2:0] push_data_i,
  input  logic       pop_i,
  output logic [2:0] pop_data_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o       = (count_q == (AW+1)'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ready_o = !full_o;
  assign do_push      = push_valid_i & !full_o;
  assign do_pop       = pop_i & !empty_o;
  assign pop_data_o   = mem_q[rd_ptr_q];

  // Storage array: written on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy; clear empties the FIFO synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/coin_score_tracker.sv
// HUD number producer: serialises coin and award events into BCD coin,
// score and lives registers through a four-state FSM.
// Handshake: an award transfers on a clock edge where award_valid and
// award_ready are both high; award_ready only changes on clock edges.
module coin_score_tracker
  import coin_score_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int START_LIVES = 3,
  parameter int COIN_CODE   = 1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [1:0]  current_state,
  input  logic        coin_evt,
  input  logic        award_valid,
  input  logic [2:0]  award_code,
  output logic        award_ready,
  output logic [3:0]  coin_tens,
  output logic [3:0]  coin_ones,
  output logic [23:0] score_bcd,
  output logic [3:0]  lives,
  output logic        life_up,
  output logic        busy,
  output fsm_state_t  dbg_state
);
  fsm_state_t  state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [3:0]  tens_q, tens_d, ones_q, ones_d, lives_q, lives_d;
  logic [23:0] score_q, score_d, work_q, work_d, addend;
  logic        carry_q, carry_d, life_up_q, life_up_d, busy_q, busy_d, over_q;
  logic [2:0]  digit_q, digit_d;
  award_code_t code_q, code_d;
  logic        title_clr, intake_en, coin_acc, pend_dec;
  logic        fifo_pop, fifo_empty, fifo_full, fifo_ready;
  logic [2:0]  fifo_data;
  logic [4:0]  bit_idx, dsum;

  assign title_clr = (game_state_t'(current_state) == GS_TITLE);
  assign intake_en = (game_state_t'(current_state) == GS_PLAYING) ||
                     (game_state_t'(current_state) == GS_DYING);
  assign coin_acc  = coin_evt & intake_en;
  assign addend    = award_addend(code_q);
  assign bit_idx   = {digit_q, 2'b00};

  award_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (frame_clk),
    .rst_n       (Reset),
    .clear_i     (title_clr),
    .push_valid_i(award_valid & intake_en),
    .push_ready_o(fifo_ready),
    .push_data_i (award_code),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Next-state and datapath: one event at a time, coins before awards.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    lives_d   = lives_q;
    score_d   = score_q;
    work_d    = work_q;
    carry_d   = carry_q;
    digit_d   = digit_q;
    code_d    = code_q;
    life_up_d = 1'b0;
    fifo_pop  = 1'b0;
    pend_dec  = 1'b0;
    dsum      = '0;
    busy_d    = (state_q != ST_IDLE) || (pend_q != 3'd0) || !fifo_empty;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 3'd0) begin
          state_d = ST_COIN_INC;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          code_d   = fifo_data;
          digit_d  = 3'd0;
          carry_d  = 1'b0;
          state_d  = ST_SCORE_ADD;
        end
      end
      ST_COIN_INC: begin
        pend_dec = 1'b1;
        if (tens_q == 4'd9 && ones_q == 4'd9) begin
          tens_d    = 4'd0;
          ones_d    = 4'd0;
          lives_d   = (lives_q == 4'd9) ? 4'd9 : lives_q + 4'd1;
          life_up_d = 1'b1;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
        code_d  = 3'(COIN_CODE);
        digit_d = 3'd0;
        carry_d = 1'b0;
        state_d = ST_SCORE_ADD;
      end
      ST_SCORE_ADD: begin
        dsum = bcd_add_digit(score_q[bit_idx +: 4], addend[bit_idx +: 4], carry_q);
        work_d[bit_idx +: 4] = dsum[3:0];
        carry_d = dsum[4];
        if (digit_q == 3'd5) state_d = ST_COMMIT;
        else                 digit_d = digit_q + 3'd1;
      end
      ST_COMMIT: begin
        score_d = carry_q ? SCORE_MAX : work_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Pending coin counter saturates at 7; a pulse coinciding with a decrement holds.
    case ({coin_acc, pend_dec})
      2'b10:   if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
      2'b01:   pend_d = pend_q - 3'd1;
      default: ;
    endcase
    if (title_clr) begin
      state_d   = ST_IDLE;
      pend_d    = 3'd0;
      tens_d    = 4'd0;
      ones_d    = 4'd0;
      lives_d   = 4'(START_LIVES);
      score_d   = '0;
      work_d    = '0;
      carry_d   = 1'b0;
      digit_d   = 3'd0;
      life_up_d = 1'b0;
      busy_d    = 1'b0;
      fifo_pop  = 1'b0;
    end
  end

  // State register; async reset abandons any in-flight operation.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      pend_q    <= 3'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      lives_q   <= 4'(START_LIVES);
      score_q   <= '0;
      work_q    <= '0;
      carry_q   <= 1'b0;
      digit_q   <= 3'd0;
      code_q    <= '0;
      life_up_q <= 1'b0;
      busy_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      work_q    <= work_d;
      carry_q   <= carry_d;
      digit_q   <= digit_d;
      code_q    <= code_d;
      life_up_q <= life_up_d;
      busy_q    <= busy_d;
      over_q    <= (game_state_t'(current_state) == GS_OVER);
    end
  end

  // In game over, pushes are accepted and silently discarded.
  assign award_ready = over_q | fifo_ready;
  assign coin_tens   = tens_q;
  assign coin_ones   = ones_q;
  assign score_bcd   = score_q;
  assign lives       = lives_q;
  assign life_up     = life_up_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_coin_score_tracker.sv
// Directed bench for coin_score_tracker.
module tb_coin_score_tracker;
  import coin_score_pkg::*;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  current_state = 2'b00;
  logic        coin_evt = 1'b0;
  logic        award_valid = 1'b0;
  logic [2:0]  award_code = 3'd0;
  logic        award_ready;
  logic [3:0]  coin_tens, coin_ones, lives;
  logic [23:0] score_bcd;
  logic        life_up, busy;
  fsm_state_t  dbg_state;

  int n_vec = 0;
  int n_miss = 0;
  int waited;
  int lu_cnt;
  int n;

  coin_score_tracker dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .current_state(current_state),
    .coin_evt     (coin_evt),
    .award_valid  (award_valid),
    .award_code   (award_code),
    .award_ready  (award_ready),
    .coin_tens    (coin_tens),
    .coin_ones    (coin_ones),
    .score_bcd    (score_bcd),
    .lives        (lives),
    .life_up      (life_up),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 frame_clk = ~frame_clk;

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_coin();
    coin_evt = 1'b1;
    step(1);
    coin_evt = 1'b0;
  endtask

  task automatic push_award(input logic [2:0] code, output int wcnt);
    wcnt = 0;
    award_valid = 1'b1;
    award_code  = code;
    while (!award_ready && wcnt < 50) begin
      step(1);
      wcnt++;
    end
    chk("push_ready_bound", {23'd0, award_ready}, 24'd1);
    step(1);
    award_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    step(2);
    while ((busy || dbg_state != ST_IDLE) && k < 300) begin
      step(1);
      k++;
    end
    chk(tag, {23'd0, busy}, 24'd0);
  endtask

  task automatic wait_add(input string tag);
    int k;
    k = 0;
    while (dbg_state != ST_SCORE_ADD && k < 20) begin
      step(1);
      k++;
    end
    chk(tag, {22'd0, dbg_state}, {22'd0, ST_SCORE_ADD});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score"}, score_bcd, 24'h000000);
    chk({tag, "_coins"}, {16'd0, coin_tens, coin_ones}, 24'h000000);
    chk({tag, "_lives"}, {20'd0, lives}, 24'd3);
    chk({tag, "_ready"}, {23'd0, award_ready}, 24'd1);
    chk({tag, "_busy"}, {23'd0, busy}, 24'd0);
    chk({tag, "_lifeup"}, {23'd0, life_up}, 24'd0);
  endtask

  initial begin
    // Reset
    step(2);
    chk_reset_vals("reset");
    Reset = 1'b1;
    current_state = 2'b01;
    step(1);

    // Single coin: ones after 2 edges, score after 9, busy drops one later
    pulse_coin();
    step(2);
    chk("coin1_ones", {20'd0, coin_ones}, 24'd1);
    step(6);
    chk("coin1_score_hold", score_bcd, 24'h000000);
    step(1);
    chk("coin1_score", score_bcd, 24'h000200);
    chk("coin1_busy_hi", {23'd0, busy}, 24'd1);
    step(1);
    chk("coin1_busy_lo", {23'd0, busy}, 24'd0);

    // Preload to 99 coins, then the wrapping coin
    for (int i = 0; i < 98; i++) begin
      pulse_coin();
      wait_idle("preload_idle");
    end
    chk("c99_coins", {16'd0, coin_tens, coin_ones}, 24'h000099);
    chk("c99_score", score_bcd, 24'h019800);
    chk("c99_lives", {20'd0, lives}, 24'd3);
    pulse_coin();
    lu_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (life_up) lu_cnt++;
      step(1);
    end
    wait_idle("c100_idle");
    chk("c100_lifeup_cnt", 24'(lu_cnt), 24'd1);
    chk("c100_coins", {16'd0, coin_tens, coin_ones}, 24'h000000);
    chk("c100_lives", {20'd0, lives}, 24'd4);
    chk("c100_score", score_bcd, 24'h020000);
    pulse_coin();
    wait_idle("c101_idle");
    chk("c101_coins", {16'd0, coin_tens, coin_ones}, 24'h000001);
    chk("c101_score", score_bcd, 24'h020200);

    // Title clear in the middle of an add with an award queued
    push_award(3'd2, waited);
    wait_add("tclr_in_add");
    push_award(3'd3, waited);
    current_state = 2'b00;
    step(1);
    chk_reset_vals("tclr");
    chk("tclr_fsm", {22'd0, dbg_state}, {22'd0, ST_IDLE});
    current_state = 2'b01;
    step(12);
    chk("tclr_score_stays", score_bcd, 24'h000000);
    chk("tclr_fifo_empty", {23'd0, busy}, 24'd0);

    // Eight coins in eight cycles while an award is in progress: 7 counted
    push_award(3'd0, waited);
    for (int i = 0; i < 8; i++) begin
      coin_evt = 1'b1;
      step(1);
    end
    coin_evt = 1'b0;
    wait_idle("sat7_idle");
    chk("sat7_coins", {16'd0, coin_tens, coin_ones}, 24'h000007);
    chk("sat7_score", score_bcd, 24'h001500);

    // Game over: coin and award ignored, ready stays high
    current_state = 2'b11;
    coin_evt = 1'b1;
    award_valid = 1'b1;
    award_code = 3'd7;
    step(1);
    coin_evt = 1'b0;
    award_valid = 1'b0;
    chk("over_ready", {23'd0, award_ready}, 24'd1);
    step(12);
    chk("over_coins", {16'd0, coin_tens, coin_ones}, 24'h000007);
    chk("over_score", score_bcd, 24'h001500);
    chk("over_busy", {23'd0, busy}, 24'd0);
    current_state = 2'b01;
    step(1);

    // FIFO full: 4 pushes fill it behind a running add, the 5th waits for a pop
    push_award(3'd0, waited);
    step(2);
    push_award(3'd7, waited);
    push_award(3'd6, waited);
    push_award(3'd5, waited);
    push_award(3'd4, waited);
    chk("full_ready_lo", {23'd0, award_ready}, 24'd0);
    push_award(3'd3, waited);
    chk("full_5th_wait", 24'(waited), 24'd3);
    wait_idle("full_idle");
    chk("full_score", score_bcd, 24'h010900);

    // Score saturation: reach 999900 then add 5000
    current_state = 2'b00;
    step(1);
    current_state = 2'b01;
    for (int i = 0; i < 199; i++) push_award(3'd7, waited);
    push_award(3'd6, waited);
    push_award(3'd6, waited);
    push_award(3'd4, waited);
    push_award(3'd0, waited);
    wait_idle("pre_sat_idle");
    chk("pre_sat_score", score_bcd, 24'h999900);
    push_award(3'd7, waited);
    wait_idle("sat_idle");
    chk("sat_score", score_bcd, 24'h999999);
    pulse_coin();
    wait_idle("sat_coin_idle");
    chk("sat_coin_coins", {16'd0, coin_tens, coin_ones}, 24'h000001);
    chk("sat_coin_score", score_bcd, 24'h999999);

    // Async reset between edges during an add
    push_award(3'd1, waited);
    wait_add("arst_in_add");
    step(2);
    #3;
    Reset = 1'b0;
    #1;
    chk_reset_vals("arst");
    chk("arst_fsm", {22'd0, dbg_state}, {22'd0, ST_IDLE});
    @(negedge frame_clk);
    Reset = 1'b1;
    step(12);
    chk("arst_after_score", score_bcd, 24'h000000);
    chk("arst_after_busy", {23'd0, busy}, 24'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
